// File: rtl/window_linebuffer_pkg.sv
// Shared pixel/window definitions for the 9x9 window line buffer and the
// downstream inner-product stage.
package window_linebuffer_pkg;

    localparam int PIX_W    = 7;
    localparam int WIN      = 9;
    localparam int WIN_AREA = WIN * WIN;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/window_linebuffer_winbuf_line.sv
// winbuf_line: one image row of pixel delay, advancing only when en is high.
// Storage is a read-first RAM of IMG_W-1 entries plus a registered read port.
module winbuf_line
    import window_linebuffer_pkg::*;
#(
    parameter int IMG_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    // The output register supplies the final stage of delay, so the RAM is
    // one entry shorter than a row. dout is consumed on the next accepted
    // pixel, giving a total delay of exactly IMG_W accepted pixels.
    localparam int DEPTH = IMG_W - 1;
    localparam int PW    = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    pixel_t          mem [0:DEPTH-1];
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   ptr_next;
    pixel_t          dout_reg;

    always_comb begin
        ptr_next = ptr_reg;
        if (en) begin
            ptr_next = (ptr_reg == PTR_LAST) ? '0 : ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg  <= '0;
            dout_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (en) begin
                dout_reg <= mem[ptr_reg];
            end
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/window_linebuffer.sv
// Streaming 9x9 window generator over a raster image using eight row delay lines.
// Optional frame_done output enabled by defining WINDOW_LINEBUFFER_FRAME_DONE_EN.
module window_linebuffer
    import window_linebuffer_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output pixel_t           xarray [0:WIN_AREA-1],
    output logic             win_valid
`ifdef WINDOW_LINEBUFFER_FRAME_DONE_EN
    ,
    output logic             frame_done
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WIN - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(WIN - 1);

    logic [CW-1:0] col_reg;
    logic [CW-1:0] col_next;
    logic [RW-1:0] row_reg;
    logic [RW-1:0] row_next;
    logic          win_valid_reg;
    logic          win_valid_next;

    pixel_t        xarray_reg  [0:WIN_AREA-1];
    pixel_t        xarray_next [0:WIN_AREA-1];
    pixel_t        line_in     [0:WIN-2];
    pixel_t        line_out    [0:WIN-2];
    pixel_t        col_in      [0:WIN-1];

    // Counters describe the position of the pixel being accepted this cycle.
    always_comb begin
        col_next       = col_reg;
        row_next       = row_reg;
        win_valid_next = 1'b0;
        if (pix_valid) begin
            win_valid_next = (row_reg >= ROW_FIRST) && (col_reg >= COL_FIRST);
            if (col_reg == COL_LAST) begin
                col_next = '0;
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg       <= '0;
            row_reg       <= '0;
            win_valid_reg <= 1'b0;
        end else begin
            col_reg       <= col_next;
            row_reg       <= row_next;
            win_valid_reg <= win_valid_next;
        end
    end

    // Delay line gi outputs the pixel gi+1 rows above the incoming one.
    genvar gi, gj;
    generate
        for (gi = 0; gi < WIN - 1; gi++) begin : g_line
            if (gi == 0) begin : g_head
                assign line_in[gi] = pix_in;
            end else begin : g_chain
                assign line_in[gi] = line_out[gi-1];
            end

            winbuf_line #(
                .IMG_W (IMG_W)
            ) u_line (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (pix_valid),
                .din   (line_in[gi]),
                .dout  (line_out[gi])
            );
        end

        // Newest column: row 8 is the live pixel, row 0 the oldest delay line.
        for (gi = 0; gi < WIN; gi++) begin : g_col
            if (gi == WIN - 1) begin : g_live
                assign col_in[gi] = pix_in;
            end else begin : g_delayed
                assign col_in[gi] = line_out[WIN-2-gi];
            end
        end

        for (gi = 0; gi < WIN; gi++) begin : g_row
            for (gj = 0; gj < WIN; gj++) begin : g_elem
                if (gj == WIN - 1) begin : g_new
                    assign xarray_next[gi*WIN+gj] = pix_valid ? col_in[gi]
                                                              : xarray_reg[gi*WIN+gj];
                end else begin : g_shift
                    assign xarray_next[gi*WIN+gj] = pix_valid ? xarray_reg[gi*WIN+gj+1]
                                                              : xarray_reg[gi*WIN+gj];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_AREA; i++) begin
                xarray_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIN_AREA; i++) begin
                xarray_reg[i] <= xarray_next[i];
            end
        end
    end

    assign xarray    = xarray_reg;
    assign win_valid = win_valid_reg;

`ifdef WINDOW_LINEBUFFER_FRAME_DONE_EN
    logic frame_done_reg;
    logic frame_done_next;

    always_comb begin
        frame_done_next = pix_valid && (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= frame_done_next;
        end
    end

    assign frame_done = frame_done_reg;
`endif

endmodule

// File: doc/window_linebuffer.md
WINDOW_LINEBUFFER -- requirements
Module: window_linebuffer

Interface
REQ-001 Parameter IMG_W, default 28: image width in pixels, legal range 9..1024.
REQ-002 Parameter IMG_H, default 28: image height in rows, legal range 9..1024.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pix_valid  input  1  pix_in carries a valid pixel this cycle; there is no backpressure.
REQ-006 pix_in  input  7  unsigned pixel, raster order, row-major.
REQ-007 xarray  output  81x7 (unpacked [0:80])  9x9 window; element r*9+c, r=0 is the top (oldest) row, c=0 is the left (oldest) column.
REQ-008 win_valid  output  1  xarray holds a complete in-frame window this cycle; one-cycle pulse per accepted pixel.
REQ-009 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted; present only under the macro (REQ-024).

Function
REQ-010 Accepted pixel = pix_valid high at a clock edge; a cycle without pix_valid shall change no state.
REQ-011 col and row counters shall track the position of the accepted pixel: col wraps IMG_W-1 -> 0 and increments row; row wraps IMG_H-1 -> 0.
REQ-012 Eight row-delay lines of IMG_W pixels each shall hold the eight previous rows; each shall advance only on an accepted pixel.
REQ-013 On each accepted pixel, the 9x9 window register shall shift one column left; new column 8 = {delay8..delay1 outputs, pix_in}, with row 8 = pix_in.
REQ-014 win_valid shall assert in the cycle after an accepted pixel at row>=8 and col>=8; otherwise it is low.
REQ-015 Latency: pixel accepted at edge N appears at xarray[80] and drives win_valid after edge N, i.e. one register stage.
REQ-016 xarray shall hold its value while pix_valid is low; win_valid shall be low during such gaps.
REQ-017 No window shall span a row wrap or a frame wrap; REQ-014 guarantees this, and stale delay-line contents never produce win_valid.
REQ-018 Windows per frame = (IMG_W-8)*(IMG_H-8); 400 for the defaults.
REQ-019 Width rule: storage is 7 bits throughout with no arithmetic on pixel values; counters are $clog2(IMG_W) and $clog2(IMG_H) bits.

Reset
REQ-020 While rst_n is low, col=0, row=0, win_valid=0, frame_done=0, and xarray all zeros.
REQ-021 Delay-line contents need no reset.
REQ-022 Reset mid-frame shall abandon the frame; the next accepted pixel is treated as (row 0, col 0).
REQ-023 No win_valid shall occur until a full 8 rows plus 9 pixels have been accepted after reset release.

Configuration
REQ-024 Macro WINDOW_LINEBUFFER_FRAME_DONE_EN: when defined, the frame_done port exists and pulses in the cycle after the accepted pixel at (IMG_H-1, IMG_W-1); when undefined, the port and its logic are absent and all other behaviour is identical.

Structure
REQ-025 The shared package shall hold PIX_W=7, WIN=9, WIN_AREA=81, and typedef pixel_t (logic [PIX_W-1:0]); the downstream inner-product stage uses the same package.
REQ-026 One sub-module, winbuf_line, shall implement a single IMG_W-deep, enable-gated pixel delay line, instantiated eight times.

Verification
REQ-027 Defaults, ramp pixel=(row*28+col)%128, continuous valid -> first win_valid after pixel 232 (row 8, col 8), with xarray[0]=0, xarray[8]=8, xarray[72]=224%128=96, xarray[80]=104.
REQ-028 Full frame continuous -> exactly 400 win_valid pulses; no pulse for col<8 or row<8.
REQ-029 Same stream with pix_valid toggled 1/0 -> identical sequence of window contents; win_valid never high in a gap cycle; xarray stable across gaps.
REQ-030 Two back-to-back frames -> second frame's first win_valid at its pixel (8,8), 800 pulses total, no window mixing frames; with macro, frame_done pulses after pixels 783 and 1567.
REQ-031 rst_n low for 1 cycle at pixel 500 -> outputs zero immediately (asynchronous); restarted ramp yields the first window exactly as in REQ-027.
REQ-032 IMG_W=9, IMG_H=9 -> exactly one win_valid, after pixel 80, with xarray[i]=i.
